// File: rtl/apb4_completer_if.sv
`default_nettype none
// ============================================================================
// Module   : apb4_completer_if
// Brief    : APB4 bus bundle between an initiator and apb4_completer.
// Revision : 1.0 - initial release
// ============================================================================
interface apb4_completer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [3:0]            PSTRB;
  logic [2:0]            PPROT;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PREADY, PRDATA, PSLVERR
  );
endinterface
`default_nettype wire

// File: rtl/apb4_completer.sv
`default_nettype none
// ============================================================================
// Module   : apb4_completer
// Brief    : APB4 completer with a DEPTH-word register file, fixed wait
//            states, byte strobes and PSLVERR on bad addresses.
// Revision : 1.0 - initial release
// ============================================================================
module apb4_completer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  wire                PCLK,
  input  wire                PRESETn,
  apb4_completer_if.slave    bus,
  output logic [7:0]         err_count
);

  localparam int                    c_idx_w = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_limit = ADDR_WIDTH'(DEPTH * 4);
  localparam logic [3:0]            c_wait  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   wr_q, wr_d;
  logic [c_idx_w-1:0]     idx_q, idx_d;
  logic                   pready_q, pready_d;
  logic                   pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]  prdata_q, prdata_d;
  logic [7:0]             err_count_q, err_count_d;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]  mem_d [DEPTH];

  logic                   setup;
  logic                   access;
  logic                   dec_err;
  logic [c_idx_w-1:0]     dec_idx;
  logic                   unused_pprot;

  assign setup        = bus.PSEL && !bus.PENABLE;
  assign access       = bus.PSEL && bus.PENABLE;
  assign dec_err      = (bus.PADDR[1:0] != 2'b00) || (bus.PADDR >= c_limit);
  assign dec_idx      = bus.PADDR[c_idx_w+1:2];
  assign unused_pprot = ^bus.PPROT;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    wr_d        = wr_q;
    idx_d       = idx_q;
    err_count_d = err_count_q;
    mem_d       = mem_q;

    // A setup phase in any state (re)starts a transfer with a fresh decode.
    if (setup) begin
      err_d   = dec_err;
      wr_d    = bus.PWRITE;
      idx_d   = dec_idx;
      cnt_d   = c_wait;
      state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_WAIT: begin
          if (!bus.PSEL) begin
            state_d = S_IDLE;
          end else if (access) begin
            if (cnt_q == 4'd1) state_d = S_RESP;
            else               cnt_d   = cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (!bus.PSEL) begin
            state_d = S_IDLE;
          end else if (access) begin
            state_d = S_IDLE;
            if (err_q) begin
              if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            end else if (wr_q) begin
              for (int b = 0; b < 4; b++) begin
                if (bus.PSTRB[b]) mem_d[idx_q][8*b +: 8] = bus.PWDATA[8*b +: 8];
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Response outputs are registered against the state being entered.
    pready_d  = (state_d == S_RESP);
    pslverr_d = (state_d == S_RESP) && err_d;
    prdata_d  = ((state_d == S_RESP) && !err_d && !wr_d) ? mem_q[idx_d] : '0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      err_q       <= 1'b0;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      err_count_q <= 8'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      wr_q        <= wr_d;
      idx_q       <= idx_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      prdata_q    <= prdata_d;
      err_count_q <= err_count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign bus.PREADY  = pready_q;
  assign bus.PSLVERR = pslverr_q;
  assign bus.PRDATA  = prdata_q;
  assign err_count   = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_apb4_completer.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb4_completer
// Brief    : Scoreboard bench for apb4_completer, plus a wait-state sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb4_completer;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int W     = 1;
  localparam int SW_W [3] = '{0, 3, 15};

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic [7:0] err_count;
  always #5 PCLK = ~PCLK;

  apb4_completer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  apb4_completer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus), .err_count(err_count)
  );

  // Wait-state sweep instances share one stimulus set.
  logic        s_psel, s_pen, s_wr;
  logic [31:0] s_addr, s_wdata;
  logic [7:0]  sw_err0, sw_err3, sw_err15;
  logic [2:0]  sw_rdy;
  logic [31:0] sw_rdata [3];

  apb4_completer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s0 ();
  apb4_completer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s3 ();
  apb4_completer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s15 ();
  apb4_completer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(s0), .err_count(sw_err0));
  apb4_completer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut_w3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(s3), .err_count(sw_err3));
  apb4_completer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(15)) dut_w15 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(s15), .err_count(sw_err15));

  assign s0.PSEL = s_psel;   assign s3.PSEL = s_psel;   assign s15.PSEL = s_psel;
  assign s0.PENABLE = s_pen; assign s3.PENABLE = s_pen; assign s15.PENABLE = s_pen;
  assign s0.PWRITE = s_wr;   assign s3.PWRITE = s_wr;   assign s15.PWRITE = s_wr;
  assign s0.PADDR = s_addr;  assign s3.PADDR = s_addr;  assign s15.PADDR = s_addr;
  assign s0.PWDATA = s_wdata; assign s3.PWDATA = s_wdata; assign s15.PWDATA = s_wdata;
  assign s0.PSTRB = 4'hF;    assign s3.PSTRB = 4'hF;    assign s15.PSTRB = 4'hF;
  assign s0.PPROT = 3'b000;  assign s3.PPROT = 3'b000;  assign s15.PPROT = 3'b000;
  assign sw_rdy      = {s15.PREADY, s3.PREADY, s0.PREADY};
  assign sw_rdata[0] = s0.PRDATA;
  assign sw_rdata[1] = s3.PRDATA;
  assign sw_rdata[2] = s15.PRDATA;

  int          n_cmp = 0;
  int          n_mis = 0;
  exp_t        sb_q [$];
  logic [31:0] m_mem [DEPTH];
  int          m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic f_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
  endfunction

  // Model update and expectation push happen as the setup phase is driven.
  task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    exp_t e;
    int   edges;
    int   idx;
    idx    = int'(a >> 2) % DEPTH;
    e.err  = f_err(a);
    e.data = '0;
    if (e.err) m_err = (m_err == 255) ? 255 : m_err + 1;
    else if (wr) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_mem[idx][8*b +: 8] = d[8*b +: 8];
    end else e.data = m_mem[idx];
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
    bus.PADDR = a;   bus.PWDATA = d;     bus.PSTRB = s;   bus.PPROT = 3'b010;
    sb_q.push_back(e);
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    edges = 1;
    while (bus.PREADY !== 1'b1 && edges < 40) begin
      @(negedge PCLK);
      edges++;
    end
    check("latency", 32'(edges), 32'(W + 1));
    @(posedge PCLK);
    @(negedge PCLK);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  always @(negedge PCLK) begin
    exp_t e;
    if (bus.PREADY === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_pslverr", 32'(bus.PSLVERR), 32'(e.err));
        check("sb_prdata", bus.PRDATA, e.data);
      end
    end else begin
      check("idle_prdata", bus.PRDATA, 32'd0);
      check("idle_pslverr", 32'(bus.PSLVERR), 32'd0);
    end
  end

  // Holds the access phase long enough for every sweep instance to finish.
  task automatic sweep_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input string tag);
    int          rise [3];
    logic        pre_bad [3];
    logic [31:0] rd_at [3];
    for (int i = 0; i < 3; i++) begin rise[i] = -1; pre_bad[i] = 1'b0; rd_at[i] = '0; end
    @(negedge PCLK);
    s_psel = 1'b1; s_pen = 1'b0; s_wr = wr; s_addr = a; s_wdata = d;
    for (int e = 1; e <= 20; e++) begin
      @(posedge PCLK);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (sw_rdy[i] && rise[i] < 0) begin
          rise[i]  = e;
          rd_at[i] = sw_rdata[i];
        end else if (rise[i] < 0 && sw_rdata[i] != 32'd0) begin
          pre_bad[i] = 1'b1;
        end
      end
      if (e == 1) s_pen = 1'b1;
    end
    s_psel = 1'b0; s_pen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_rise_w%0d", tag, SW_W[i]), 32'(rise[i]), 32'(SW_W[i] + 1));
      check($sformatf("%s_pre_w%0d", tag, SW_W[i]), 32'(pre_bad[i]), 32'd0);
      if (!wr) check($sformatf("%s_data_w%0d", tag, SW_W[i]), rd_at[i], d);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    PRESETn = 1'b0;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0;
    bus.PWDATA = '0; bus.PSTRB = '0;     bus.PPROT = '0;
    s_psel = 1'b0; s_pen = 1'b0; s_wr = 1'b0; s_addr = '0; s_wdata = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_err = 0;
    repeat (2) @(negedge PCLK);
    check("rst_pready", 32'(bus.PREADY), 32'd0);
    check("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
    check("rst_prdata", bus.PRDATA, 32'd0);
    check("rst_errcnt", 32'(err_count), 32'd0);
    PRESETn = 1'b1;

    // Out-of-range and misaligned writes must fault and leave memory clean.
    apb_xfer(1'b1, 32'h0000_01F4, 32'hFFFF_FFFF, 4'hF);
    apb_xfer(1'b1, 32'h0000_0002, 32'hFFFF_FFFF, 4'hF);
    check("errcnt_2", 32'(err_count), 32'd2);
    for (int i = 0; i < DEPTH; i++) apb_xfer(1'b0, 32'(i * 4), 32'd0, 4'h0);

    apb_xfer(1'b1, 32'h0000_0000, 32'h0000_0009, 4'hF);
    apb_xfer(1'b0, 32'h0000_0000, 32'd0, 4'h0);
    apb_xfer(1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'hF);
    apb_xfer(1'b1, 32'h0000_0008, 32'h1122_3344, 4'h5);
    apb_xfer(1'b0, 32'h0000_0008, 32'd0, 4'h0);
    apb_xfer(1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h0);
    apb_xfer(1'b0, 32'h0000_0000, 32'd0, 4'hF);
    apb_xfer(1'b1, 32'h0000_003C, 32'hDEAD_BEEF, 4'hF);
    apb_xfer(1'b0, 32'h0000_003C, 32'd0, 4'h0);
    apb_xfer(1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF);
    apb_xfer(1'b0, 32'h0000_0001, 32'd0, 4'h0);
    check("errcnt_model", 32'(err_count), 32'(m_err));

    // Abort: PSEL dropped while the write is still waiting.
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'h4; bus.PWDATA = 32'hCAFE_F00D; bus.PSTRB = 4'hF;
    @(negedge PCLK);
    check("abort_wait_rdy", 32'(bus.PREADY), 32'd0);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b1;
    repeat (3) begin
      @(negedge PCLK);
      check("abort_rdy", 32'(bus.PREADY), 32'd0);
    end
    bus.PENABLE = 1'b0;
    apb_xfer(1'b0, 32'h0000_0004, 32'd0, 4'h0);
    check("abort_errcnt", 32'(err_count), 32'(m_err));

    // Reset asserted while a write sits in its response cycle.
    apb_xfer(1'b1, 32'h0000_000C, 32'h0000_0005, 4'hF);
    apb_xfer(1'b0, 32'h0000_000C, 32'd0, 4'h0);
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'hC; bus.PWDATA = 32'h7777_7777; bus.PSTRB = 4'hF;
    @(posedge PCLK);
    #1;
    bus.PENABLE = 1'b1;
    edges = 1;
    while (bus.PREADY !== 1'b1 && edges < 40) begin
      @(posedge PCLK);
      #1;
      edges++;
    end
    check("rstmid_reached_resp", 32'(bus.PREADY), 32'd1);
    PRESETn = 1'b0;
    #1;
    check("rstmid_pready", 32'(bus.PREADY), 32'd0);
    check("rstmid_prdata", bus.PRDATA, 32'd0);
    check("rstmid_pslverr", 32'(bus.PSLVERR), 32'd0);
    check("rstmid_errcnt", 32'(err_count), 32'd0);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_err = 0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    apb_xfer(1'b0, 32'h0000_000C, 32'd0, 4'h0);

    sweep_xfer(1'b1, 32'h0000_0004, 32'h1234_5678, "sw_wr");
    sweep_xfer(1'b0, 32'h0000_0004, 32'h1234_5678, "sw_rd");

    repeat (2) @(negedge PCLK);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
